div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle radix-2 restoring divider in the EX stage. It consumes the ID-stage decode flags isdiv and signeddiv, which arrive here as start and signed_div, together with the rs/rt operand values. It produces quotient (LO) and remainder (HI) for the HILO write path, which uses hiwrite/lowrite. While a division is in flight it drives a stall request to the hazard unit.

Parameters:
WIDTH, 32, operand/result width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  reset.
start  in  1  division request (isdiv of the instruction in EX); level, held by the pipeline while stalled.
signed_div  in  1  1 = DIV, 0 = DIVU; sampled with start.
a  in  WIDTH  dividend (rs value).
b  in  WIDTH  divisor (rt value).
cancel  in  1  exception/flush; aborts any operation.
stall_div  out  1  stall request to hazard unit.
valid  out  1  one-cycle strobe: lo/hi hold a finished result.
lo  out  WIDTH  quotient.
hi  out  WIDTH  remainder.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset: state=IDLE, counter=0, valid=0, lo=0, hi=0, stall_div=0. Reset mid-operation discards the operation with no valid.
- States: IDLE, CALC, DONE.
- IDLE: when start=1 and cancel=0, accept the request.
  - Latch |a| and |b| (two's-complement magnitude if signed_div, else raw), sign_q = a[31]^b[31], sign_r = a[31]. Sign flags are 0 when unsigned.
  - Clear the partial remainder. Go to CALC with counter=0.
  - If b==0, go straight to DONE instead, with lo=32'hFFFFFFFF and hi=a (fixed, defined result).
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left 1. Trial-subtract the divisor from the upper WIDTH+1 bits. If the result is non-negative, keep it and set quo[0]=1.
  - After WIDTH steps (counter==WIDTH-1), go to DONE.
- DONE: registered lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem. valid=1 for exactly this cycle. Next state is IDLE unconditionally.
- Latency: accept at cycle t; valid at t+WIDTH+1 (t+33). Divide-by-zero: valid at t+1.
- stall_div = (IDLE & start & ~cancel) | CALC. It is combinational, so the requesting instruction stalls in its first cycle. It is low in DONE so the pipeline advances.
- start still high in DONE belongs to the finishing instruction and is ignored. A new request is accepted only from IDLE, so back-to-back divides are spaced by at least one IDLE cycle.
- cancel: from any state, go to IDLE next cycle with valid=0. lo/hi keep their previous values. cancel in DONE suppresses valid. cancel has priority over start.
- Operand changes on a/b/signed_div after acceptance have no effect.
- Signed overflow 0x80000000 / -1 yields lo=0x80000000, hi=0 (natural magnitude arithmetic, no trap).
- lo/hi change only in DONE (or on reset). Between operations they are stable.

Test Plan:
- Unsigned 100/7: start=1, signed_div=0, a=100, b=7 -> stall_div high for 33 cycles, valid at t+33 with lo=14, hi=2; then IDLE, stall_div=0.
- Signed -7/2: a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Same operands unsigned -> lo=0x7FFFFFFC, hi=1.
- Edge operands: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Divide by zero (a=0x1234, b=0) -> valid at t+1, lo=0xFFFFFFFF, hi=0x1234.
- cancel asserted 10 cycles into CALC -> IDLE next cycle, no valid, lo/hi unchanged. Then a new 100/7 completes correctly.
- start held high through DONE, followed by a new start after one IDLE cycle -> exactly one valid per operation, no spurious restart. Second op 0xFFFFFFFF/16 unsigned -> lo=0x0FFFFFFF, hi=15.
- resetn pulsed low mid-CALC -> lo=hi=0, valid=0, stall_div=0 immediately (asynchronous), no valid after release.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces quotient (lo) and remainder (hi) with a one-cycle valid strobe and a stall request.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall_div,
    output logic             valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   counter_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               valid_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic               stall_req;

    logic               accept;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign accept = start && !cancel;
    assign b_zero = (b == '0);
    assign a_mag  = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag  = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One restoring step: shift the next dividend bit into the remainder, keep the
    // trial difference only when it did not borrow.
    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};
    always_comb begin
        rem_next = rem_shift[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        if (!rem_diff[WIDTH]) begin
            rem_next = rem_diff[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_req  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    stall_req  = 1'b1;
                    state_next = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                stall_req = 1'b1;
                if (cancel)
                    state_next = IDLE;
                else if (counter_reg == CNT_W'(WIDTH - 1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Held low while reset is asserted even if the pipeline keeps start high.
    assign stall_div = resetn && stall_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            valid_reg   <= 1'b0;
            lo_reg      <= '0;
            hi_reg      <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        counter_reg <= '0;
                        divisor_reg <= b_mag;
                        if (b_zero) begin
                            // Defined divide-by-zero result flows through DONE unsigned.
                            quo_reg    <= '1;
                            rem_reg    <= a;
                            sign_q_reg <= 1'b0;
                            sign_r_reg <= 1'b0;
                        end else begin
                            quo_reg    <= a_mag;
                            rem_reg    <= '0;
                            sign_q_reg <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                            sign_r_reg <= signed_div && a[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        rem_reg     <= rem_next;
                        quo_reg     <= quo_next;
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (!cancel) begin
                        lo_reg    <= sign_q_reg ? (~quo_reg + 1'b1) : quo_reg;
                        hi_reg    <= sign_r_reg ? (~rem_reg + 1'b1) : rem_reg;
                        valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = valid_reg;
    assign lo    = lo_reg;
    assign hi    = hi_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed edge cases plus randomized divisions
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        stall_div;
    logic        valid;
    logic [31:0] lo;
    logic [31:0] hi;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall_div  (stall_div),
        .valid      (valid),
        .lo         (lo),
        .hi         (hi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        if (y == 0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (sgn) begin
            sx = $signed(x);
            sy = $signed(y);
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Full transaction: request, scramble operands after acceptance, wait for valid.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [31:0] eq, er;
        int stall_cnt, lat, extra;
        logic got, drop, held;
        ref_div(x, y, sgn, eq, er);
        stall_cnt = 0; lat = -1; got = 0; drop = 0; held = 1; extra = 0;
        @(negedge clk);
        a = x; b = y; signed_div = sgn; start = 1'b1;
        #1;
        if (stall_div) stall_cnt++;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
            end
            if (drop) start = 1'b0;
            #1;
            if (valid) begin
                got = 1; lat = k;
                break;
            end
            if (lo !== last_lo || hi !== last_hi) held = 0;
            if (!stall_div) drop = 1;
            else stall_cnt++;
        end
        start = 1'b0;
        check("timeout", 32'(got), 32'd1);
        check("latency", lat, (y == 0) ? 32'd1 : 32'd33);
        check("stall_cycles", stall_cnt, (y == 0) ? 32'd1 : 32'd33);
        check("lo_hold", 32'(held), 32'd1);
        check("lo", lo, eq);
        check("hi", hi, er);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (valid || stall_div) extra++;
        end
        check("no_restart", extra, 32'd0);
        last_lo = eq;
        last_hi = er;
        $display("op a=%h b=%h signed=%0d lo=%h hi=%h lat=%0d", x, y, sgn, lo, hi, lat);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (valid || stall_div) seen++;
        end
        check(tag, seen, 32'd0);
        check({tag, "_lo"}, lo, last_lo);
        check({tag, "_hi"}, hi, last_hi);
    endtask

    initial begin
        #2;
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stall", 32'(stall_div), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        check("neg7_lo", last_lo, 32'hFFFF_FFFD);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h0000_1234, 32'd0, 1'b0);
        run_op(32'h0000_1234, 32'd0, 1'b1);

        // Cancel ten cycles into CALC.
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (11) @(negedge clk);
        cancel = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        #1;
        check("cancel_stall", 32'(stall_div), 32'd0);
        watch_quiet("cancel_quiet", 40);
        $display("op cancel mid-CALC lo=%h hi=%h", lo, hi);

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd16, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = $urandom_range(1, 20);
                1: y = 32'd0;
                2: y = -32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            run_op(x, y, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-CALC with start still held.
        @(negedge clk);
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_lo", lo, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_stall", 32'(stall_div), 32'd0);
        @(negedge clk);
        start = 1'b0;
        resetn = 1'b1;
        last_lo = '0;
        last_hi = '0;
        watch_quiet("arst_quiet", 40);
        $display("op reset mid-CALC lo=%h hi=%h", lo, hi);

        run_op(32'd100, 32'd7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
